// File: rtl/tpu_host_master.sv
// rtl/tpu_host_master.sv - turns host LOAD_A/LOAD_B/RUN/READ_C commands into tpuv1 bus transactions
// Define TPU_HOST_MASTER_TXCNT_EN to build the tx_count bus transaction counter.
module tpu_host_master #(
  parameter int               BITS_AB    = 8,
  parameter int               BITS_C     = 16,
  parameter int               DIM        = 8,
  parameter int               ADDRW      = 16,
  parameter int               DATAW      = 64,
  parameter logic [ADDRW-1:0] A_BASE     = 16'h0100,
  parameter logic [ADDRW-1:0] B_BASE     = 16'h0200,
  parameter logic [ADDRW-1:0] C_BASE     = 16'h0300,
  parameter logic [ADDRW-1:0] MM_ADDR    = 16'h0400,
  parameter int               RUN_CYCLES = 3*DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DATAW-1:0] wr_data,
  output logic             rd_valid,
  output logic [DATAW-1:0] rd_data,
  output logic             rd_last,
  output logic             done,
  output logic [31:0]      tx_count,
  output logic             bus_r_w,
  output logic [ADDRW-1:0] bus_addr,
  output logic [DATAW-1:0] bus_wdata,
  input  logic [DATAW-1:0] bus_rdata
);
  localparam int AB_WORDS = DIM*DIM*BITS_AB/DATAW;
  localparam int C_WORDS  = DIM*DIM*BITS_C/DATAW;
  localparam int IDXW     = (C_WORDS > AB_WORDS) ? $clog2(C_WORDS) : $clog2(AB_WORDS);
  localparam int CNTW     = $clog2(RUN_CYCLES + 1);
  localparam logic [ADDRW-1:0] STRIDE  = ADDRW'(DATAW/8);
  localparam logic [IDXW-1:0]  AB_LAST = IDXW'(AB_WORDS - 1);
  localparam logic [IDXW-1:0]  C_LAST  = IDXW'(C_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TRIG, S_WAIT, S_RDADDR, S_DRAIN} state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [ADDRW-1:0] base_q;
  logic [CNTW-1:0]  cnt_q;
  logic             cmd_ready_q, wr_ready_q, rd_valid_q, rd_last_q, done_q, bus_r_w_q;
  logic [DATAW-1:0] rd_data_q, bus_wdata_q;
  logic [ADDRW-1:0] bus_addr_q;

  // The bus defaults to an idle cycle (read of unmapped address 0) unless a state issues a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      bus_r_w_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      bus_r_w_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            idx_q       <= '0;
            case (cmd_op)
              2'd0, 2'd1: begin
                state_q    <= S_LOAD;
                wr_ready_q <= 1'b1;
                base_q     <= (cmd_op == 2'd0) ? A_BASE : B_BASE;
              end
              2'd2: begin
                state_q    <= S_TRIG;
                bus_r_w_q  <= 1'b1;
                bus_addr_q <= MM_ADDR;
              end
              default: begin
                state_q    <= S_RDADDR;
                bus_addr_q <= C_BASE;
                idx_q      <= IDXW'(1);
              end
            endcase
          end
        end
        S_LOAD: begin
          if (wr_valid && wr_ready_q) begin
            bus_r_w_q   <= 1'b1;
            bus_addr_q  <= base_q + ADDRW'(idx_q) * STRIDE;
            bus_wdata_q <= wr_data;
            idx_q       <= idx_q + IDXW'(1);
            if (idx_q == AB_LAST) begin
              state_q     <= S_IDLE;
              wr_ready_q  <= 1'b0;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        S_TRIG: begin
          state_q <= S_WAIT;
          cnt_q   <= CNTW'(RUN_CYCLES);
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
          end
        end
        S_RDADDR: begin
          // Read data answers the address of the previous cycle, so capture and re-issue together.
          rd_valid_q <= 1'b1;
          rd_data_q  <= bus_rdata;
          bus_addr_q <= C_BASE + ADDRW'(idx_q) * STRIDE;
          idx_q      <= idx_q + IDXW'(1);
          if (idx_q == C_LAST) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          rd_valid_q  <= 1'b1;
          rd_data_q   <= bus_rdata;
          rd_last_q   <= 1'b1;
          done_q      <= 1'b1;
          cmd_ready_q <= 1'b1;
          idx_q       <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef TPU_HOST_MASTER_TXCNT_EN
  logic [31:0] tx_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count_q <= '0;
    end else if (bus_r_w_q || (bus_addr_q != '0)) begin
      tx_count_q <= tx_count_q + 32'd1;
    end
  end

  assign tx_count = tx_count_q;
`else
  assign tx_count = 32'd0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign done      = done_q;
  assign bus_r_w   = bus_r_w_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_tpu_host_master.sv
// tb/tb_tpu_host_master.sv - randomized self-checking bench for tpu_host_master
// Expected bus/result traffic is built from the command rules and compared with a negedge monitor log.
module tb_tpu_host_master;
  localparam int AB_WORDS   = 8;
  localparam int C_WORDS    = 16;
  localparam int RUN_CYCLES = 24;
`ifdef TPU_HOST_MASTER_TXCNT_EN
  localparam bit TXEN = 1'b1;
`else
  localparam bit TXEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_data = '0;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        done;
  logic [31:0] tx_count;
  logic        bus_r_w;
  logic [15:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic [31:0] rd_salt = 32'h0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct packed { int c; logic rw; logic [15:0] addr; logic [63:0] data; } bus_t;
  typedef struct packed { int c; logic [63:0] data; logic last; } rd_t;
  bus_t bus_log[$];
  rd_t  rd_log[$];
  int   done_log[$];

  tpu_host_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done), .tx_count(tx_count),
    .bus_r_w(bus_r_w), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // TPU model: read data is a salted function of the address being presented.
  assign bus_rdata = {rd_salt, 16'h5A5A, bus_addr};

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_r_w || bus_addr != 16'h0) bus_log.push_back('{cyc, bus_r_w, bus_addr, bus_wdata});
      if (rd_valid) rd_log.push_back('{cyc, rd_data, rd_last});
      if (done) done_log.push_back(cyc);
    end
  end

  task automatic issue_cmd(input logic [1:0] op, output int acc, output bit ok);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (cmd_ready === 1'b1);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    acc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, rd_last, done, bus_r_w} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {cmd_ready, wr_ready, rd_valid, rd_last, done, bus_r_w});
    checks++;
    if ({bus_addr, bus_wdata, rd_data, tx_count} !== '0)
      $display("FAIL reset_buses: got addr=%h wdata=%h rdata=%h tx=%0d want all 0", bus_addr, bus_wdata, rd_data, tx_count);
    if ({bus_addr, bus_wdata, rd_data, tx_count} !== '0 || {cmd_ready, wr_ready, rd_valid, rd_last, done, bus_r_w} !== 6'b0)
      errors++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  // mode 0: back to back, 1: valid every other cycle, 2: random gaps
  task automatic test_load(input logic [1:0] op, input int mode, input bit seq_words);
    logic [63:0] words [AB_WORDS];
    logic [15:0] base;
    bus_t exp[$];
    int acc, k, guard, last_c, rdy_bad, got_done;
    bit ok, v;
    base = (op == 2'd0) ? 16'h0100 : 16'h0200;
    for (int i = 0; i < AB_WORDS; i++) words[i] = seq_words ? 64'(32'h11 + i) : {$urandom(), $urandom()};
    bus_log.delete();
    done_log.delete();
    wr_valid = 1'b1;
    wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) @(negedge clk);
    issue_cmd(op, acc, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL load_accept: cmd_ready got %b want 1", ok);
    end
    k = 0;
    guard = 0;
    rdy_bad = 0;
    while (k < AB_WORDS && guard < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc - acc) % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      if (v) begin
        if (wr_ready !== 1'b1) rdy_bad++;
        wr_valid = 1'b1;
        wr_data = words[k];
        exp.push_back('{cyc + 1, 1'b1, base + 16'(8 * k), words[k]});
        k++;
      end else begin
        wr_valid = 1'b0;
        wr_data = {$urandom(), $urandom()};
      end
      guard++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    last_c = cyc;
    repeat (3) @(negedge clk);
    checks++;
    if (rdy_bad !== 0) begin
      errors++;
      $display("FAIL load_wr_ready: %0d offered words saw wr_ready low, want 0", rdy_bad);
    end
    checks++;
    if (bus_log.size() !== AB_WORDS) begin
      errors++;
      $display("FAIL load_count: got %0d bus transactions want %0d", bus_log.size(), AB_WORDS);
    end
    for (int i = 0; i < AB_WORDS && i < bus_log.size(); i++) begin
      checks++;
      if (bus_log[i] !== exp[i]) begin
        errors++;
        $display("FAIL load_write[%0d]: got c=%0d rw=%b addr=%h data=%h want c=%0d rw=%b addr=%h data=%h", i,
                 bus_log[i].c, bus_log[i].rw, bus_log[i].addr, bus_log[i].data,
                 exp[i].c, exp[i].rw, exp[i].addr, exp[i].data);
      end
    end
    got_done = (done_log.size() == 1) ? done_log[0] : -1;
    checks++;
    if (got_done !== last_c) begin
      errors++;
      $display("FAIL load_done: got cycle %0d (%0d pulses) want cycle %0d", got_done, done_log.size(), last_c);
    end
    checks++;
    if (wr_ready !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_idle_after: got wr_ready=%b cmd_ready=%b want 0 1", wr_ready, cmd_ready);
    end
  endtask

  task automatic test_run();
    int acc, guard, ready_hi;
    bit ok;
    bus_t want;
    bus_log.delete();
    done_log.delete();
    issue_cmd(2'd2, acc, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL run_accept: cmd_ready got %b want 1", ok);
    end
    guard = 0;
    ready_hi = 0;
    while (done !== 1'b1 && guard < 100) begin
      if (cmd_ready !== 1'b0) ready_hi++;
      guard++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== acc + RUN_CYCLES + 1 || done !== 1'b1) begin
      errors++;
      $display("FAIL run_done_time: got done=%b at cycle %0d want 1 at %0d", done, cyc, acc + RUN_CYCLES + 1);
    end
    checks++;
    if (ready_hi !== 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_cmd_ready: got %0d busy cycles ready, ready=%b at done want 0 and 1", ready_hi, cmd_ready);
    end
    want = '{acc, 1'b1, 16'h0400, 64'h0};
    checks++;
    if (bus_log.size() !== 1 || bus_log[0] !== want) begin
      errors++;
      $display("FAIL run_trigger: got %0d txns first c=%0d rw=%b addr=%h data=%h want 1 txn c=%0d write 0400 data 0",
               bus_log.size(), bus_log[0].c, bus_log[0].rw, bus_log[0].addr, bus_log[0].data, acc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_c();
    int acc, got_done;
    bit ok;
    bus_t wb;
    rd_t wr;
    rd_salt = $urandom();
    bus_log.delete();
    rd_log.delete();
    done_log.delete();
    issue_cmd(2'd3, acc, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL read_accept: cmd_ready got %b want 1", ok);
    end
    repeat (C_WORDS + 4) @(negedge clk);
    checks++;
    if (bus_log.size() !== C_WORDS || rd_log.size() !== C_WORDS) begin
      errors++;
      $display("FAIL read_count: got %0d reads %0d words want %0d each", bus_log.size(), rd_log.size(), C_WORDS);
    end
    for (int i = 0; i < C_WORDS && i < bus_log.size(); i++) begin
      wb = '{acc + i, 1'b0, 16'h0300 + 16'(8 * i), 64'h0};
      checks++;
      if (bus_log[i] !== wb) begin
        errors++;
        $display("FAIL read_addr[%0d]: got c=%0d rw=%b addr=%h want c=%0d rw=0 addr=%h", i,
                 bus_log[i].c, bus_log[i].rw, bus_log[i].addr, wb.c, wb.addr);
      end
    end
    for (int i = 0; i < C_WORDS && i < rd_log.size(); i++) begin
      wr = '{acc + 1 + i, {rd_salt, 16'h5A5A, 16'h0300 + 16'(8 * i)}, (i == C_WORDS - 1)};
      checks++;
      if (rd_log[i] !== wr) begin
        errors++;
        $display("FAIL read_word[%0d]: got c=%0d data=%h last=%b want c=%0d data=%h last=%b", i,
                 rd_log[i].c, rd_log[i].data, rd_log[i].last, wr.c, wr.data, wr.last);
      end
    end
    got_done = (done_log.size() == 1) ? done_log[0] : -1;
    checks++;
    if (got_done !== acc + C_WORDS) begin
      errors++;
      $display("FAIL read_done: got cycle %0d want %0d", got_done, acc + C_WORDS);
    end
  endtask

  task automatic test_reset_mid_load();
    int acc;
    bit ok;
    bus_log.delete();
    issue_cmd(2'd0, acc, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL abort_accept: cmd_ready got %b want 1", ok);
    end
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data = {$urandom(), $urandom()};
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, rd_last, done, bus_r_w, bus_addr, bus_wdata, tx_count} !== '0) begin
      errors++;
      $display("FAIL abort_async: got ready=%b wr_ready=%b r_w=%b addr=%h wdata=%h tx=%0d want all 0",
               cmd_ready, wr_ready, bus_r_w, bus_addr, bus_wdata, tx_count);
    end
    checks++;
    if (bus_log.size() !== 4) begin
      errors++;
      $display("FAIL abort_writes: got %0d writes before reset want 4", bus_log.size());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_release_ready: got %b want 1", cmd_ready);
    end
    test_load(2'd0, 0, 1'b0);
  endtask

  task automatic test_tx_count();
    test_run();
    checks++;
    if (tx_count !== (TXEN ? 32'd9 : 32'd0)) begin
      errors++;
      $display("FAIL tx_after_run: got %0d want %0d", tx_count, TXEN ? 9 : 0);
    end
    test_read_c();
    checks++;
    if (tx_count !== (TXEN ? 32'd25 : 32'd0)) begin
      errors++;
      $display("FAIL tx_after_read: got %0d want %0d", tx_count, TXEN ? 25 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_load(2'd0, 0, 1'b1);
    test_load(2'd1, 1, 1'b0);
    test_load(2'd0, 2, 1'b0);
    test_run();
    test_read_c();
    test_reset_mid_load();
    test_tx_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
